// File: rtl/instr_loader.sv
// Instruction loader: encodes ISA fields into 8-bit words and streams them into
// instruction memory, holding the CPU in reset until the session completes.
module instr_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op_class,
  input  logic [1:0]        rs,
  input  logic [1:0]        rt,
  input  logic [1:0]        rd,
  input  logic [1:0]        imm,
  input  logic [5:0]        target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              load_done,
  output logic              cpu_hold
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(DEPTH - 1);

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [7:0]          enc;
  logic                accept;

  always_comb begin
    enc = 8'h00;
    case (op_class)
      2'b00:   enc = {2'b00, rs, rt, rd};
      2'b01:   enc = {2'b01, rs, rt, imm};
      2'b10:   enc = {2'b10, rs, rt, imm};
      default: enc = {2'b11, target};
    endcase
  end

  assign accept = in_valid & in_ready;

  // State register plus the registered write port and session counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD;
          count_d = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          wdata_d = enc;
          count_d = count_q + 1'b1;
        end
        // A same-cycle finish still lets the accepted word through.
        if (finish || (accept && count_q == LAST)) state_d = DRAIN;
      end
      default: state_d = DONE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == LOAD) && (count_q < FULL);
    load_done = (state_q == DONE);
    cpu_hold  = (state_q != DONE);
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: expected writes go into a scoreboard queue
// when driven and are popped whenever the DUT raises imem_we.
module tb_instr_loader;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  typedef struct packed { logic [ADDR_W-1:0] a; logic [7:0] d; } wr_t;

  logic              clk = 1'b0;
  logic              rst_n, start, finish, in_valid, in_ready;
  logic [1:0]        op_class, rs, rt, rd, imm;
  logic [5:0]        target;
  logic              imem_we, load_done, cpu_hold;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_wdata;
  logic [ADDR_W:0]   count;

  wr_t sb[$];
  int  total = 0;
  int  bad   = 0;

  instr_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .op_class(op_class),
    .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .count(count), .load_done(load_done), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setf(input logic [1:0] o, input logic [1:0] a, input logic [1:0] b,
                      input logic [1:0] c, input logic [1:0] im, input logic [5:0] tg);
    op_class = o; rs = a; rt = b; rd = c; imm = im; target = tg;
  endtask

  task automatic push(input int a, input logic [7:0] d);
    wr_t w;
    w.a = ADDR_W'(a);
    w.d = d;
    sb.push_back(w);
  endtask

  // Advance one edge, then match any write the DUT presents against the queue.
  task automatic tick();
    wr_t w;
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      if (sb.size() == 0) chk("we_unexpected", 32'(imem_we), 32'd0);
      else begin
        w = sb.pop_front();
        chk("waddr", 32'(imem_addr), 32'(w.a));
        chk("wdata", 32'(imem_wdata), 32'(w.d));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    setf(2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 6'd0);
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", 32'(imem_wdata), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Four back-to-back accepts of each class, then finish.
    start = 1'b1; tick(); start = 1'b0;
    chk("load_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    setf(2'b00, 2'd1, 2'd2, 2'd3, 2'd0, 6'd0); push(0, 8'h1B); tick();
    setf(2'b01, 2'd0, 2'd1, 2'd0, 2'd2, 6'd0); push(1, 8'h46); tick();
    setf(2'b10, 2'd2, 2'd3, 2'd0, 2'd1, 6'd0); push(2, 8'hAD); tick();
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h05); push(3, 8'hC5); tick();
    chk("t1_count", 32'(count), 32'd4);
    in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0;
    chk("t1_we_after", 32'(imem_we), 32'd0);
    chk("t1_not_done_yet", 32'(load_done), 32'd0);
    tick();
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("t1_in_ready", 32'(in_ready), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // in_valid 1,0,1: write gap in the idle cycle.
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_count_clr", 32'(count), 32'd0);
    chk("t2_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t2_load_done", 32'(load_done), 32'd0);
    in_valid = 1'b1; setf(2'b00, 2'd0, 2'd0, 2'd0, 2'd0, 6'd0); push(0, 8'h00); tick();
    in_valid = 1'b0; tick();
    chk("t2_gap_we", 32'(imem_we), 32'd0);
    in_valid = 1'b1; setf(2'b00, 2'd0, 2'd0, 2'd1, 2'd0, 6'd0); push(1, 8'h01); tick();
    in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0; tick();
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_load_done", 32'(load_done), 32'd1);

    // Fill to DEPTH without finish; data word i encodes as i.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("t3_in_ready", 32'(in_ready), 32'd1);
      setf(2'b00, 2'(i >> 4), 2'(i >> 2), 2'(i), 2'd0, 6'd0);
      push(i, 8'(i));
      tick();
    end
    chk("t3_ready_drop", 32'(in_ready), 32'd0);
    chk("t3_count", 32'(count), 32'(DEPTH));
    tick();
    chk("t3_we_done", 32'(imem_we), 32'd0);
    chk("t3_load_done", 32'(load_done), 32'd1);
    chk("t3_count_hold", 32'(count), 32'(DEPTH));
    in_valid = 1'b0;

    // finish together with an accept.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; finish = 1'b1;
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h3F); push(0, 8'hFF); tick();
    in_valid = 1'b0; finish = 1'b0;
    chk("t4_drain_ready", 32'(in_ready), 32'd0);
    chk("t4_drain_done", 32'(load_done), 32'd0);
    chk("t4_count", 32'(count), 32'd1);
    tick();
    chk("t4_load_done", 32'(load_done), 32'd1);

    // Asynchronous reset mid-session with in_valid held.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h10); push(0, 8'hD0); tick();
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h11); push(1, 8'hD1); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t5_we", 32'(imem_we), 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_cpu_hold", 32'(cpu_hold), 32'd1);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    chk("t5_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("t5_we_in_rst", 32'(imem_we), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("t5_idle_ready", 32'(in_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h2A); push(0, 8'hEA); tick();
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h01); push(1, 8'hC1); tick();
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h02); push(2, 8'hC2); tick();
    in_valid = 1'b0; finish = 1'b1; tick(); finish = 1'b0; tick();
    chk("t5_count3", 32'(count), 32'd3);
    chk("t5_done", 32'(load_done), 32'd1);

    // Zero-length session from DONE, then start ignored inside LOAD.
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_count_clr", 32'(count), 32'd0);
    chk("t6_hold", 32'(cpu_hold), 32'd1);
    finish = 1'b1; tick(); finish = 1'b0;
    chk("t6_drain_done", 32'(load_done), 32'd0);
    tick();
    chk("t6_done", 32'(load_done), 32'd1);
    chk("t6_count0", 32'(count), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1;
    setf(2'b11, 2'd0, 2'd0, 2'd0, 2'd0, 6'h33); push(0, 8'hF3); tick();
    in_valid = 1'b0; start = 1'b1; tick(); start = 1'b0;
    chk("t6_start_ignored", 32'(count), 32'd1);
    chk("t6_still_load", 32'(in_ready), 32'd1);
    finish = 1'b1; tick(); finish = 1'b0; tick();
    chk("t6_final_done", 32'(load_done), 32'd1);
    chk("t6_final_count", 32'(count), 32'd1);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
# instr_loader

Encodes program instructions into the 8-bit ISA (op[7:6]: 00 R-type, 01 lw, 10 sw, 11 jump) and writes them sequentially into instruction memory before execution. It sits between the board-level program source (switches or test bench) and the instruction memory write port. It holds the CPU in reset while loading and releases it when the program is complete. It produces the words that the CPU's control decoder later consumes.

## Interface
Parameters:
- DEPTH, 32, instruction memory depth in words (power of 2, ≥ 2)
- ADDR_W, 5, log2(DEPTH)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a load session (sampled in IDLE or DONE)
- finish  in  1  end session early (sampled in LOAD)
- in_valid  in  1  instruction fields valid
- in_ready  out  1  loader accepts fields this cycle
- op_class  in  2  00 R, 01 lw, 10 sw, 11 jump
- rs, rt, rd  in  2 each  register fields
- imm  in  2  lw/sw offset
- target  in  6  jump target
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  8  encoded instruction
- count  out  ADDR_W+1  words accepted this session
- load_done  out  1  session complete
- cpu_hold  out  1  high keeps CPU in reset

## Operation
- Encoding, combinational from the fields, registered only on accept:
  - R: {00, rs, rt, rd}
  - lw: {01, rs, rt, imm}
  - sw: {10, rs, rt, imm}
  - jump: {11, target}
  - Unused fields are ignored.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - in_ready=0, cpu_hold=1, load_done=0.
  - start → LOAD; count cleared to 0.
- LOAD:
  - in_ready=1 while count<DEPTH.
  - Accept occurs when in_valid & in_ready.
  - On accept: imem_wdata←encoded word, imem_addr←count[ADDR_W-1:0], imem_we←1 (registered), count←count+1.
  - With no accept, imem_we←0.
- LOAD exits:
  - LOAD → DRAIN on finish, or on the accept that makes count=DEPTH.
  - finish and an accept in the same cycle: the word is accepted and written, then DRAIN.
- DRAIN:
  - Exactly one cycle; in_ready=0.
  - Carries the final registered write if one is pending.
  - Always → DONE.
- DONE:
  - load_done=1, cpu_hold=0, in_ready=0, imem_we=0.
  - count holds the session length.
  - start → LOAD: count cleared, cpu_hold=1, load_done=0.
- start while in LOAD/DRAIN is ignored.
- finish outside LOAD is ignored.
- Zero-length session (finish on the first LOAD cycle): count=0, no writes, DONE.
- The address never wraps: accepts stop at DEPTH. Memory at addresses ≥ count is left untouched.

## Timing
- Reset values: state IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, load_done=0, cpu_hold=1.
- Reset asserted mid-session: all of the above apply immediately (asynchronous). No write is issued after rst_n falls.
- Accept at edge t: imem_we/addr/wdata are valid for the cycle after edge t, so memory captures at edge t+1.
- Throughput is one word per cycle and latency is one cycle.
- Back-to-back accepts give a continuous imem_we with incrementing addresses.
- in_ready is combinational from state and count only, never from in_valid.
- Last accept at edge t: DRAIN during cycle t..t+1 with imem_we=1; DONE from edge t+1.
- load_done and cpu_hold change on the same edge.
- count updates at the accept edge.

## Test plan
- Reset, start, then four back-to-back accepts (R rs=1 rt=2 rd=3; lw rs=0 rt=1 imm=2; sw rs=2 rt=3 imm=1; jump target=0x05), then finish → writes 0x1B@0, 0x46@1, 0xAD@2, 0xC5@3 on consecutive cycles; count=4; load_done=1 and cpu_hold=0 two cycles after the last accept.
- in_valid toggled 1,0,1 with R words rd=0,1 → two writes at addresses 0,1 with a one-cycle imem_we gap; no write during the idle cycle.
- Fill: DEPTH consecutive accepts with no finish → in_ready drops after word DEPTH-1 is accepted; last write at address DEPTH-1; count=DEPTH; DONE without finish.
- finish asserted in the same cycle as an accept of jump target=0x3F → 0xFF is written; DRAIN, then DONE; count includes that word.
- rst_n pulled low two cycles into a load session with in_valid held → imem_we=0 immediately, count=0, cpu_hold=1, state IDLE; a new start reloads from address 0.
- From DONE (count=3), start and immediately finish → count=0, no writes, load_done re-asserts after DRAIN; start during LOAD is ignored (count is not cleared).
